// File: rtl/key_pkg.sv
// Shared constants and types for the key event path (debouncer -> scheduler -> beep/segment).
package key_pkg;

  localparam int unsigned KEY_NUM  = 4;
  localparam int unsigned KEY_ID_W = 2;
  localparam int unsigned BEEP_W   = 27;

  typedef logic [KEY_ID_W-1:0] key_id_t;

  // 100 ms at 50 MHz
  localparam logic [BEEP_W-1:0] BEEP_CYC_DFLT = 27'd5_000_000;

endpackage

// File: rtl/key_evt_fifo.sv
// Circular event FIFO; head data reads as zero while empty.
module key_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign count  = r_count;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/key_evt_sched.sv
// Key event scheduler: pending bits, round-robin arbiter, event FIFO and beep timer.
module key_evt_sched
  import key_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [BEEP_W-1:0] BEEP_CYC   = BEEP_CYC_DFLT
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [KEY_NUM-1:0] key_pulse,
  input  logic               evt_ready,
  output logic               evt_valid,
  output key_id_t            evt_id,
  output logic               beep_on,
  output logic               drop_flag
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [KEY_NUM-1:0] r_pend;
  key_id_t            r_rr_ptr;
  logic               r_drop;
  logic [BEEP_W-1:0]  r_beep_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_space;
  logic [CW-1:0]      w_count;
  key_id_t            w_head;
  key_id_t            w_idx;
  key_id_t            w_gnt_id;
  logic               w_gnt_vld;
  logic [KEY_NUM-1:0] w_gnt_oh;
  logic [KEY_NUM-1:0] w_lost;

  // Slot check uses the registered count so a same-cycle pop never frees a slot.
  assign w_space = (w_count < CW'(FIFO_DEPTH));
  assign w_pop   = !w_empty && evt_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < KEY_NUM; k++) begin
      w_idx = r_rr_ptr + key_id_t'(k);
      if (!w_gnt_vld && w_space && r_pend[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  assign w_gnt_oh = w_gnt_vld ? (KEY_NUM'(1) << w_gnt_id) : '0;
  // A fresh pulse beats a same-cycle grant; only a pulse on a still-held bit is lost.
  assign w_lost   = key_pulse & r_pend & ~w_gnt_oh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend     <= '0;
      r_rr_ptr   <= '0;
      r_drop     <= 1'b0;
      r_beep_cnt <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gnt_oh) | key_pulse;
      if (|w_lost)   r_drop   <= 1'b1;
      if (w_gnt_vld) r_rr_ptr <= w_gnt_id + key_id_t'(1);
      if (w_pop)                  r_beep_cnt <= BEEP_CYC;
      else if (r_beep_cnt != '0)  r_beep_cnt <= r_beep_cnt - BEEP_W'(1);
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KEY_ID_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_gnt_vld),
    .wdata (w_gnt_id),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign evt_valid = !w_empty;
  assign evt_id    = w_head;
  assign beep_on   = (r_beep_cnt != '0);
  assign drop_flag = r_drop;

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rstn) w_full |-> !w_gnt_vld);

endmodule

// File: tb/tb_key_evt_sched.sv
// Self-checking bench for key_evt_sched: vector table, directed sequences, random vs queue model.
module tb_key_evt_sched;

  localparam int DEPTH = 4;
  localparam int BEEP  = 8;

  logic       clk;
  logic       rstn;
  logic [3:0] key_pulse;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       beep_on;
  logic       drop_flag;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;

  // Reference model state
  bit m_pend[4];
  int m_rr;
  int mq[$];
  int m_beep;
  bit m_drop;

  key_evt_sched #(
    .FIFO_DEPTH (DEPTH),
    .BEEP_CYC   (27'd8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_pulse (key_pulse),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .beep_on   (beep_on),
    .drop_flag (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pulse;
    logic       ready;
    logic       valid;
    logic [1:0] id;
    logic       beep;
    logic       drop;
  } vec_t;

  vec_t tv[24];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_rr   = 0;
    mq     = {};
    m_beep = 0;
    m_drop = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] p, input logic r);
    bit pop;
    int gnt;
    pop = (mq.size() > 0) && r;
    gnt = -1;
    if (mq.size() < DEPTH)
      for (int k = 0; k < 4; k++)
        if (gnt < 0 && m_pend[(m_rr + k) % 4]) gnt = (m_rr + k) % 4;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (m_pend[i] && i != gnt) m_drop = 1'b1;
        m_pend[i] = 1'b1;
      end else if (i == gnt) begin
        m_pend[i] = 1'b0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (gnt >= 0) begin
      mq.push_back(gnt);
      m_rr = (gnt + 1) % 4;
    end
    if (pop) m_beep = BEEP;
    else if (m_beep > 0) m_beep--;
  endtask

  // Called at a negedge: compare against the model, drive, clock, return at next negedge.
  task automatic tick(input logic [3:0] p, input logic r);
    chk("model_valid", int'(evt_valid), int'(mq.size() > 0));
    chk("model_id", int'(evt_id), (mq.size() > 0) ? mq[0] : 0);
    chk("model_beep", int'(beep_on), int'(m_beep != 0));
    chk("model_drop", int'(drop_flag), int'(m_drop));
    if (evt_valid && r) n_pops++;
    key_pulse = p;
    evt_ready = r;
    @(posedge clk);
    model_step(p, r);
    @(negedge clk);
    key_pulse = 4'b0000;
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    key_pulse = 4'b0000;
    evt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int exp3[3];
    logic [3:0] rp;
    logic       rr;

    for (int c = 0; c < 24; c++) begin
      tv[c].pulse = (c == 10) ? 4'b0100 : 4'b0000;
      tv[c].ready = 1'b1;
      tv[c].valid = (c == 12);
      tv[c].id    = (c == 12) ? 2'd2 : 2'd0;
      tv[c].beep  = (c >= 13 && c <= 20);
      tv[c].drop  = 1'b0;
    end

    // Single press, table-driven; row 0 also covers reset values
    do_reset();
    chk("rst_rr_ptr", int'(dut.r_rr_ptr), 0);
    chk("rst_count", int'(dut.w_count), 0);
    chk("rst_pend", int'(dut.r_pend), 0);
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("t1_valid_c%0d", c), int'(evt_valid), int'(tv[c].valid));
      chk($sformatf("t1_id_c%0d", c), int'(evt_id), int'(tv[c].id));
      chk($sformatf("t1_beep_c%0d", c), int'(beep_on), int'(tv[c].beep));
      chk($sformatf("t1_drop_c%0d", c), int'(drop_flag), int'(tv[c].drop));
      tick(tv[c].pulse, tv[c].ready);
    end

    // Simultaneous four-key press
    do_reset();
    tick(4'b1111, 1'b0);
    repeat (4) tick(4'b0000, 1'b0);
    chk("t2_count_full", int'(dut.w_count), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_valid_%0d", i), int'(evt_valid), 1);
      chk($sformatf("t2_id_%0d", i), int'(evt_id), i);
      tick(4'b0000, 1'b1);
    end
    chk("t2_empty", int'(evt_valid), 0);
    chk("t2_rr_ptr", int'(dut.r_rr_ptr), 0);

    // Round-robin after a grant to key 1 (pointer at 2: key 0 precedes key 1)
    do_reset();
    tick(4'b0010, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0011, 1'b0);
    repeat (3) tick(4'b0000, 1'b0);
    exp3 = '{1, 0, 1};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_id_%0d", i), int'(evt_id), exp3[i]);
      tick(4'b0000, 1'b1);
    end
    chk("t3_empty", int'(evt_valid), 0);

    // Full queue, held press, then drop
    do_reset();
    tick(4'b1111, 1'b0);
    repeat (4) tick(4'b0000, 1'b0);
    tick(4'b0001, 1'b0);
    repeat (2) tick(4'b0000, 1'b0);
    chk("t4_count_held", int'(dut.w_count), 4);
    chk("t4_pend0_held", int'(dut.r_pend[0]), 1);
    chk("t4_no_drop_yet", int'(drop_flag), 0);
    tick(4'b0001, 1'b0);
    chk("t4_drop_rise", int'(drop_flag), 1);
    n_pops = 0;
    repeat (10) tick(4'b0000, 1'b1);
    chk("t4_pop_total", n_pops, 5);
    chk("t4_drop_sticky", int'(drop_flag), 1);

    // Beep retrigger: pops at P and P+3
    do_reset();
    tick(4'b0011, 1'b0);
    repeat (3) tick(4'b0000, 1'b0);
    chk("t5_beep_idle", int'(beep_on), 0);
    tick(4'b0000, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      chk($sformatf("t5_beep_p%0d", k), int'(beep_on), 1);
      tick(4'b0000, (k == 3) ? 1'b1 : 1'b0);
    end
    chk("t5_beep_p12", int'(beep_on), 0);

    // Asynchronous reset mid-operation
    do_reset();
    tick(4'b1111, 1'b0);
    repeat (4) tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
    chk("t6_count_pre", int'(dut.w_count), 3);
    chk("t6_beep_pre", int'(beep_on), 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_valid_rst", int'(evt_valid), 0);
    chk("t6_id_rst", int'(evt_id), 0);
    chk("t6_beep_rst", int'(beep_on), 0);
    chk("t6_drop_rst", int'(drop_flag), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_stale_%0d", i), int'(evt_valid), 0);
      tick(4'b0000, 1'b1);
    end

    // Random traffic against the queue model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 4; b++) rp[b] = ($urandom_range(0, 9) < 2);
      if ((c % 250) < 80) rr = ($urandom_range(0, 7) == 0);
      else                rr = ($urandom_range(0, 3) != 0);
      tick(rp, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
